// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timer and its dead-time output stage.
// The break/fault path is only built when PWM_DT_BRK_EN is defined.
package pwm_pkg;

  // Matches the PWM timer's counter width so dead_time can come straight from it.
  localparam int PWM_DT_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ON_L  = 3'd1,
    DT_H  = 3'd2,
    ON_H  = 3'd3,
    DT_L  = 3'd4,
    FAULT = 3'd5
  } dt_state_e;

  // Steady drive state that corresponds to a given wave level.
  function automatic logic [2:0] dt_drive_state(input logic wave);
    return wave ? ON_H : ON_L;
  endfunction

endpackage

// File: rtl/pwm_dt_counter.sv
// Dead-interval down-counter: load, decrement towards zero, zero flag.
// Kept separate so a multi-channel wrapper can reuse one per channel.
module pwm_dt_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate drive with programmable dead time from a PWM wave.
// Define PWM_DT_BRK_EN to add the brk input and the latched FAULT state.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = PWM_DT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            wave_in,
  input  logic [DT_W-1:0] dead_time,
`ifdef PWM_DT_BRK_EN
  input  logic            brk,
`endif
  output logic            out_h,
  output logic            out_l,
  output logic            dead,
  output logic            fault,
  output logic [2:0]      state_dbg
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_ON_L  = ON_L;
  localparam logic [2:0] S_DT_H  = DT_H;
  localparam logic [2:0] S_ON_H  = ON_H;
  localparam logic [2:0] S_DT_L  = DT_L;
`ifdef PWM_DT_BRK_EN
  localparam logic [2:0] S_FAULT = FAULT;
`endif

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       out_h_q;
  logic       out_l_q;
  logic       dead_q;
  logic       cnt_clr;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       dt_zero;

  // The counter holds dead_time-1 so that the phase lasts exactly dead_time cycles.
  pwm_dt_counter #(.W(DT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (dead_time - DT_W'(1)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign dt_zero = (dead_time == '0);
  assign cnt_dec = (state_q == S_DT_H) || (state_q == S_DT_L);

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
`ifdef PWM_DT_BRK_EN
    if (brk) begin
      state_d = S_FAULT;
      cnt_clr = 1'b1;
    end else if (state_q == S_FAULT) begin
      if (!en) state_d = S_IDLE;
    end else
`endif
    if (!en) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dt_zero) begin
            state_d = dt_drive_state(wave_in);
          end else begin
            state_d  = wave_in ? S_DT_H : S_DT_L;
            cnt_load = 1'b1;
          end
        end
        S_ON_L: begin
          if (wave_in) begin
            state_d  = dt_zero ? S_ON_H : S_DT_H;
            cnt_load = !dt_zero;
          end
        end
        S_ON_H: begin
          if (!wave_in) begin
            state_d  = dt_zero ? S_ON_L : S_DT_L;
            cnt_load = !dt_zero;
          end
        end
        // A glitch that reverts during the phase lands back on the old side with no second dead phase.
        S_DT_H, S_DT_L: begin
          if (cnt_zero) state_d = dt_drive_state(wave_in);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_h_q <= 1'b0;
      out_l_q <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_h_q <= (state_d == S_ON_H);
      out_l_q <= (state_d == S_ON_L);
      dead_q  <= (state_d == S_DT_H) || (state_d == S_DT_L);
    end
  end

`ifdef PWM_DT_BRK_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign out_h     = out_h_q;
  assign out_l     = out_l_q;
  assign dead      = dead_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed scenarios plus random stimulus against a cycle-level model.
// Builds with or without PWM_DT_BRK_EN; brk stimulus is ignored by the model when absent.
module tb_pwm_deadtime;

`ifdef PWM_DT_BRK_EN
  localparam bit BRK_PRESENT = 1'b1;
`else
  localparam bit BRK_PRESENT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        wave_in;
  logic [15:0] dead_time;
  logic        brk;
  logic        out_h;
  logic        out_l;
  logic        dead;
  logic        fault;
  logic [2:0]  state_dbg;

  pwm_deadtime #(.DT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wave_in   (wave_in),
    .dead_time (dead_time),
`ifdef PWM_DT_BRK_EN
    .brk       (brk),
`endif
    .out_h     (out_h),
    .out_l     (out_l),
    .dead      (dead),
    .fault     (fault),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected {fault, dead, out_h, out_l} per cycle
  logic [3:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: which side is driven (0 none, 1 low, 2 high), dead cycles left, fault latch
  int m_drive     = 0;
  int m_dead_left = 0;
  bit m_fault     = 1'b0;

  task automatic model_step(input logic r, input logic e, input logic w,
                            input logic [15:0] dt, input logic b);
    logic b_eff;
    b_eff = BRK_PRESENT & b;
    if (!r) begin
      m_drive = 0; m_dead_left = 0; m_fault = 1'b0;
    end else if (b_eff) begin
      m_drive = 0; m_dead_left = 0; m_fault = 1'b1;
    end else if (m_fault) begin
      if (!e) m_fault = 1'b0;
    end else if (!e) begin
      m_drive = 0; m_dead_left = 0;
    end else if (m_dead_left > 0) begin
      m_dead_left = m_dead_left - 1;
      if (m_dead_left == 0) m_drive = w ? 2 : 1;
    end else if (m_drive == 0 || (m_drive == 1 && w) || (m_drive == 2 && !w)) begin
      if (dt == 16'd0) begin
        m_drive = w ? 2 : 1;
      end else begin
        m_drive = 0;
        m_dead_left = int'(dt);
      end
    end
  endtask

  // driver: apply inputs for the next rising edge and push the model's prediction
  task automatic step(input logic r, input logic e, input logic w,
                      input logic [15:0] dt, input logic b);
    @(negedge clk);
    rst_n = r; en = e; wave_in = w; dead_time = dt; brk = b;
    model_step(r, e, w, dt, b);
    exp_q.push_back({m_fault, (m_dead_left > 0), (m_drive == 2), (m_drive == 1)});
  endtask

  task automatic hold(input int n, input logic r, input logic e, input logic w,
                      input logic [15:0] dt, input logic b);
    for (int i = 0; i < n; i++) step(r, e, w, dt, b);
  endtask

  // monitor: pop one expectation per edge and compare, plus the overlap invariant
  always @(posedge clk) begin
    logic [3:0] exp_v;
    logic [3:0] act_v;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {fault, dead, out_h, out_l};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got fault/dead/h/l=%b required %b", cyc, act_v, exp_v);
      end
      n_tests++;
      if ((out_h & out_l) !== 1'b0) begin
        n_fail++;
        $display("FAIL overlap cycle %0d: out_h=%b out_l=%b required not both 1", cyc, out_h, out_l);
      end
    end
  end

  initial begin
    logic w;
    logic e;
    logic b;
    logic r;
    logic [15:0] dt;
    rst_n = 1'b0; en = 1'b0; wave_in = 1'b0; dead_time = 16'd0; brk = 1'b0;

    hold(3, 0, 0, 0, 16'd3, 0);
    // first enable: full dead interval then low side
    hold(6, 1, 1, 0, 16'd3, 0);
    // rising wave with dead_time 5
    hold(10, 1, 1, 1, 16'd5, 0);
    hold(10, 1, 1, 0, 16'd5, 0);
    // zero dead time: direct swaps
    for (int k = 0; k < 6; k++) hold(4, 1, 1, k[0], 16'd0, 0);
    // short pulse swallowed by dead_time 4
    hold(6, 1, 1, 0, 16'd4, 0);
    hold(2, 1, 1, 1, 16'd4, 0);
    hold(8, 1, 1, 0, 16'd4, 0);
    // dead_time changed mid-phase
    step(1, 1, 1, 16'd3, 0);
    hold(6, 1, 1, 1, 16'd7, 0);
    // en dropped mid dead phase, then re-enabled
    hold(3, 1, 1, 0, 16'd6, 0);
    hold(2, 1, 0, 0, 16'd6, 0);
    hold(10, 1, 1, 0, 16'd6, 0);
    // break during high drive
    hold(8, 1, 1, 1, 16'd2, 0);
    step(1, 1, 1, 16'd2, 1);
    hold(3, 1, 1, 1, 16'd2, 0);
    hold(2, 1, 0, 1, 16'd2, 0);
    hold(6, 1, 1, 1, 16'd2, 0);
    // reset in the middle of a dead phase
    hold(2, 1, 1, 0, 16'd5, 0);
    step(0, 1, 0, 16'd5, 0);
    hold(8, 1, 1, 0, 16'd5, 0);

    // random phase
    w = 1'b0; e = 1'b1; dt = 16'd2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) w = ~w;
      if ($urandom_range(0, 19) == 0) dt = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) e = ~e;
      b = ($urandom_range(0, 149) == 0);
      r = ($urandom_range(0, 299) != 0);
      step(r, e, w, dt, b);
    end

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
